// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Holds the FSM state encoding and the length helper functions.
package seq_det_pkg;

    // Pattern lengths are limited to this many bits.
    localparam int MAX_LEN_LIMIT = 32;

    typedef enum logic {
        SCAN  = 1'b0,
        MATCH = 1'b1
    } state_t;

    // Width needed to hold a length value 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Lengths above the window size collapse to the full window.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift window with fill tracking and masked pattern compare.
// Produces a combinational hit for the bit being shifted in this cycle.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               overlap,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit,
    output logic               busy
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic               shift;

    // Next window contents, saturating fill and the masked compare.
    always_comb begin
        shift     = bit_valid & ~load;
        hist_next = {hist[MAX_LEN-2:0], bit_in};
        if (fill >= len) begin
            fill_next = len;
        end else begin
            fill_next = fill + LEN_W'(1);
        end
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift
            && (len != '0)
            && (fill_next >= len)
            && (((hist_next ^ pattern) & mask) == '0);
    end

    // Shift register of received bits; a load only suppresses shifting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist <= '0;
        end else if (shift) begin
            hist <= hist_next;
        end
    end

    // Valid-bit count; a non-overlapping match restarts the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fill <= '0;
        end else if (load) begin
            fill <= '0;
        end else if (shift) begin
            if (hit && !overlap) begin
                fill <= '0;
            end else begin
                fill <= fill_next;
            end
        end
    end

    assign busy = (fill != '0);

endmodule

// File: rtl/seq_det_param_moore.sv
// Programmable Moore sequence detector: config registers, match FSM
// and a saturating match counter around the history window.
module seq_det_param_moore
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           sequence_in,
    input  logic                           sequence_valid,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clear,
    output logic                           detector_out,
    output logic [CNT_W-1:0]               match_count,
    output logic                           busy
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [LEN_W-1:0]   len_clamped;
    logic               hit;
    state_t             state;
    state_t             state_next;

    assign len_clamped = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

    // Configuration capture; reset leaves a full-width zero pattern.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pattern <= '0;
            len     <= LEN_W'(MAX_LEN);
            overlap <= 1'b1;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
        end
    end

    seq_det_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clock     (clock),
        .reset     (reset),
        .load      (cfg_load),
        .overlap   (overlap),
        .bit_valid (sequence_valid),
        .bit_in    (sequence_in),
        .pattern   (pattern),
        .len       (len),
        .hit       (hit),
        .busy      (busy)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only a qualified hit reaches or stays in MATCH.
    always_comb begin
        state_next = SCAN;
        if (!cfg_load && hit) begin
            state_next = MATCH;
        end
    end

    // Moore output decoded from the state alone.
    always_comb begin
        detector_out = (state == MATCH);
    end

    // Match counter; clear wins over an increment, holds at all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            match_count <= '0;
        end else if (cnt_clear) begin
            match_count <= '0;
        end else if (state_next == MATCH && match_count != '1) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_param_moore.sv
// Scoreboard bench for seq_det_param_moore: drivers queue expected
// outputs per cycle, a monitor pops and compares after each edge.
module tb_seq_det_param_moore;

    typedef struct {
        string nm;
        logic  det;
        int    cnt;
        logic  busy;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: 16-bit counter
    logic        a_reset = 1'b1;
    logic        a_in = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_load = 1'b0;
    logic [7:0]  a_pat = '0;
    logic [3:0]  a_len = '0;
    logic        a_ov = 1'b0;
    logic        a_clr = 1'b0;
    logic        a_det;
    logic [15:0] a_cnt;
    logic        a_busy;

    // Instance B: 2-bit counter for saturation
    logic        b_reset = 1'b1;
    logic        b_in = 1'b0;
    logic        b_valid = 1'b0;
    logic        b_load = 1'b0;
    logic [7:0]  b_pat = '0;
    logic [3:0]  b_len = '0;
    logic        b_ov = 1'b0;
    logic        b_clr = 1'b0;
    logic        b_det;
    logic [1:0]  b_cnt;
    logic        b_busy;

    seq_det_param_moore #(.MAX_LEN(8), .CNT_W(16)) u_a (
        .clock          (clock),
        .reset          (a_reset),
        .sequence_in    (a_in),
        .sequence_valid (a_valid),
        .cfg_load       (a_load),
        .cfg_pattern    (a_pat),
        .cfg_len        (a_len),
        .cfg_overlap    (a_ov),
        .cnt_clear      (a_clr),
        .detector_out   (a_det),
        .match_count    (a_cnt),
        .busy           (a_busy)
    );

    seq_det_param_moore #(.MAX_LEN(8), .CNT_W(2)) u_b (
        .clock          (clock),
        .reset          (b_reset),
        .sequence_in    (b_in),
        .sequence_valid (b_valid),
        .cfg_load       (b_load),
        .cfg_pattern    (b_pat),
        .cfg_len        (b_len),
        .cfg_overlap    (b_ov),
        .cnt_clear      (b_clr),
        .detector_out   (b_det),
        .match_count    (b_cnt),
        .busy           (b_busy)
    );

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input string fld,
                       input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d",
                     nm, fld, act, req);
        end
    endtask

    // Monitor: compare the outputs produced by each rising edge.
    always @(posedge clock) begin
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk(ea.nm, "det", int'(a_det), int'(ea.det));
            chk(ea.nm, "cnt", int'(a_cnt), ea.cnt);
            chk(ea.nm, "busy", int'(a_busy), int'(ea.busy));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk(eb.nm, "det", int'(b_det), int'(eb.det));
            chk(eb.nm, "cnt", int'(b_cnt), eb.cnt);
            chk(eb.nm, "busy", int'(b_busy), int'(eb.busy));
        end
    end

    task automatic push_a(input string nm, input logic d,
                          input int c, input logic b);
        exp_t e;
        e.nm = nm; e.det = d; e.cnt = c; e.busy = b;
        qa.push_back(e);
    endtask

    task automatic push_b(input string nm, input logic d,
                          input int c, input logic b);
        exp_t e;
        e.nm = nm; e.det = d; e.cnt = c; e.busy = b;
        qb.push_back(e);
    endtask

    // One cycle on A: rst, clr, valid, bit, then expected det/cnt/busy.
    task automatic cyc_a(input string nm, input logic rst,
                         input logic clr, input logic v,
                         input logic d, input logic e_det,
                         input int e_cnt, input logic e_busy);
        @(negedge clock);
        a_reset = rst; a_load = 1'b0; a_clr = clr;
        a_valid = v; a_in = d;
        push_a(nm, e_det, e_cnt, e_busy);
    endtask

    task automatic ld_a(input string nm, input logic [7:0] pat,
                        input logic [3:0] len, input logic ov,
                        input logic v, input logic d,
                        input logic e_det, input int e_cnt,
                        input logic e_busy);
        @(negedge clock);
        a_reset = 1'b1; a_load = 1'b1; a_clr = 1'b0;
        a_pat = pat; a_len = len; a_ov = ov;
        a_valid = v; a_in = d;
        push_a(nm, e_det, e_cnt, e_busy);
    endtask

    task automatic cyc_b(input string nm, input logic rst,
                         input logic clr, input logic v,
                         input logic d, input logic e_det,
                         input int e_cnt, input logic e_busy);
        @(negedge clock);
        b_reset = rst; b_load = 1'b0; b_clr = clr;
        b_valid = v; b_in = d;
        push_b(nm, e_det, e_cnt, e_busy);
    endtask

    task automatic ld_b(input string nm, input logic [7:0] pat,
                        input logic [3:0] len, input logic ov,
                        input logic e_det, input int e_cnt,
                        input logic e_busy);
        @(negedge clock);
        b_reset = 1'b1; b_load = 1'b1; b_clr = 1'b0;
        b_pat = pat; b_len = len; b_ov = ov;
        b_valid = 1'b0; b_in = 1'b0;
        push_b(nm, e_det, e_cnt, e_busy);
    endtask

    initial begin
        // reset held three cycles
        cyc_a("rst0", 0, 0, 0, 0, 0, 0, 0);
        cyc_a("rst1", 0, 0, 0, 0, 0, 0, 0);
        cyc_a("rst2", 0, 0, 0, 0, 0, 0, 0);

        // 1011, overlap: input 0,0,1,0,1,1,0,1,1
        ld_a("ld_ov1", 8'h0B, 4'd4, 1, 0, 0, 0, 0, 0);
        cyc_a("ov1_b1", 1, 0, 1, 0, 0, 0, 1);
        cyc_a("ov1_b2", 1, 0, 1, 0, 0, 0, 1);
        cyc_a("ov1_b3", 1, 0, 1, 1, 0, 0, 1);
        cyc_a("ov1_b4", 1, 0, 1, 0, 0, 0, 1);
        cyc_a("ov1_b5", 1, 0, 1, 1, 0, 0, 1);
        cyc_a("ov1_b6", 1, 0, 1, 1, 1, 1, 1);
        cyc_a("ov1_b7", 1, 0, 1, 0, 0, 1, 1);
        cyc_a("ov1_b8", 1, 0, 1, 1, 0, 1, 1);
        cyc_a("ov1_b9", 1, 0, 1, 1, 1, 2, 1);
        cyc_a("ov1_idle", 1, 0, 0, 0, 0, 2, 1);

        // same input, non-overlap; load keeps the count
        ld_a("ld_ov0", 8'h0B, 4'd4, 0, 0, 0, 0, 2, 0);
        cyc_a("ov0_b1", 1, 0, 1, 0, 0, 2, 1);
        cyc_a("ov0_b2", 1, 0, 1, 0, 0, 2, 1);
        cyc_a("ov0_b3", 1, 0, 1, 1, 0, 2, 1);
        cyc_a("ov0_b4", 1, 0, 1, 0, 0, 2, 1);
        cyc_a("ov0_b5", 1, 0, 1, 1, 0, 2, 1);
        cyc_a("ov0_b6", 1, 0, 1, 1, 1, 3, 0);
        cyc_a("ov0_b7", 1, 0, 1, 0, 0, 3, 1);
        cyc_a("ov0_b8", 1, 0, 1, 1, 0, 3, 1);
        cyc_a("ov0_b9", 1, 0, 1, 1, 0, 3, 1);
        cyc_a("clr", 1, 1, 0, 0, 0, 0, 1);

        // 1,0,1,1 with invalid gaps
        ld_a("ld_gap", 8'h0B, 4'd4, 1, 0, 0, 0, 0, 0);
        cyc_a("gap_b1", 1, 0, 1, 1, 0, 0, 1);
        cyc_a("gap_g1", 1, 0, 0, 0, 0, 0, 1);
        cyc_a("gap_b2", 1, 0, 1, 0, 0, 0, 1);
        cyc_a("gap_g2", 1, 0, 0, 1, 0, 0, 1);
        cyc_a("gap_b3", 1, 0, 1, 1, 0, 0, 1);
        cyc_a("gap_g3", 1, 0, 0, 0, 0, 0, 1);
        cyc_a("gap_b4", 1, 0, 1, 1, 1, 1, 1);
        cyc_a("gap_g4", 1, 0, 0, 1, 0, 1, 1);

        // back-to-back overlap matches, pattern 11
        ld_a("ld_b2b", 8'h03, 4'd2, 1, 0, 0, 0, 1, 0);
        cyc_a("b2b_1", 1, 0, 1, 1, 0, 1, 1);
        cyc_a("b2b_2", 1, 0, 1, 1, 1, 2, 1);
        cyc_a("b2b_3", 1, 0, 1, 1, 1, 3, 1);
        cyc_a("b2b_idle", 1, 0, 0, 0, 0, 3, 1);

        // reload mid-pattern, bit on the load cycle ignored
        ld_a("ld_mid", 8'h0B, 4'd4, 1, 0, 0, 0, 3, 0);
        cyc_a("mid_b1", 1, 0, 1, 1, 0, 3, 1);
        cyc_a("mid_b2", 1, 0, 1, 0, 0, 3, 1);
        cyc_a("mid_b3", 1, 0, 1, 1, 0, 3, 1);
        ld_a("mid_ld2", 8'h0B, 4'd4, 1, 1, 1, 0, 3, 0);
        cyc_a("mid_b4", 1, 0, 1, 1, 0, 3, 1);

        // reload while in MATCH
        ld_a("ld_m", 8'h03, 4'd2, 1, 0, 0, 0, 3, 0);
        cyc_a("m_b1", 1, 0, 1, 1, 0, 3, 1);
        cyc_a("m_b2", 1, 0, 1, 1, 1, 4, 1);
        ld_a("m_ld", 8'h03, 4'd2, 1, 1, 1, 0, 4, 0);

        // cfg_len 15 clamps to 8, pattern A5
        ld_a("ld_clamp", 8'hA5, 4'd15, 1, 0, 0, 0, 4, 0);
        cyc_a("cl_b1", 1, 0, 1, 1, 0, 4, 1);
        cyc_a("cl_b2", 1, 0, 1, 0, 0, 4, 1);
        cyc_a("cl_b3", 1, 0, 1, 1, 0, 4, 1);
        cyc_a("cl_b4", 1, 0, 1, 0, 0, 4, 1);
        cyc_a("cl_b5", 1, 0, 1, 0, 0, 4, 1);
        cyc_a("cl_b6", 1, 0, 1, 1, 0, 4, 1);
        cyc_a("cl_b7", 1, 0, 1, 0, 0, 4, 1);
        cyc_a("cl_b8", 1, 0, 1, 1, 1, 5, 1);

        // len 0 disables detection
        ld_a("ld_len0", 8'h00, 4'd0, 1, 0, 0, 0, 5, 0);
        cyc_a("l0_b1", 1, 0, 1, 0, 0, 5, 0);
        cyc_a("l0_b2", 1, 0, 1, 0, 0, 5, 0);

        // reset mid-sequence
        ld_a("ld_rst", 8'h0B, 4'd4, 1, 0, 0, 0, 5, 0);
        cyc_a("rm_b1", 1, 0, 1, 1, 0, 5, 1);
        cyc_a("rm_b2", 1, 0, 1, 0, 0, 5, 1);
        cyc_a("rm_b3", 1, 0, 1, 1, 0, 5, 1);
        cyc_a("rm_rst", 0, 0, 1, 1, 0, 0, 0);
        cyc_a("rm_b4", 1, 0, 1, 1, 0, 0, 1);
        cyc_a("rm_b5", 1, 0, 0, 0, 0, 0, 1);

        // B: len 1, non-overlap, all ones, 2-bit counter
        cyc_b("b_rst", 0, 0, 0, 0, 0, 0, 0);
        ld_b("b_ld", 8'h01, 4'd1, 0, 0, 0, 0);
        cyc_b("b_1", 1, 0, 1, 1, 1, 1, 0);
        cyc_b("b_2", 1, 0, 1, 1, 1, 2, 0);
        cyc_b("b_3", 1, 0, 1, 1, 1, 3, 0);
        cyc_b("b_sat1", 1, 0, 1, 1, 1, 3, 0);
        cyc_b("b_sat2", 1, 0, 1, 1, 1, 3, 0);
        cyc_b("b_zero", 1, 0, 1, 0, 0, 3, 1);
        cyc_b("b_clr", 1, 1, 1, 1, 1, 0, 0);
        cyc_b("b_after", 1, 0, 1, 1, 1, 1, 0);

        @(negedge clock);
        b_valid = 1'b0; b_clr = 1'b0;
        a_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clock);
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0",
                     qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
